mux_l1_tx: RTL



---
 rtl/mux_l1_pkg.sv | 12 +
 rtl/mux_l1_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_l1_pkg.sv
// rtl/mux_l1_pkg.sv - shared types and constants for the layer-1 transmit multiplexer
package mux_l1_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } link_state_e;

    localparam int NUM_LANES = 4;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;

endpackage

// File: rtl/mux_l1_tx.sv
// rtl/mux_l1_tx.sv - interleaves four slow byte lanes onto two clk_2f lanes with IDLE/RUN gating
// Optional MUX_L1_IDLE_FILL_EN: invalid output slots drive IDLE_BYTE instead of 0/pass-through data.
module mux_l1_tx
    import mux_l1_pkg::*;
#(
    parameter int BW = 8,
    parameter int IDLE_GROUPS = 4,
    parameter logic [BW-1:0] IDLE_BYTE = BW'(IDLE_BYTE_DEF)
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic [BW-1:0] data_tx0,
    input  logic [BW-1:0] data_tx1,
    input  logic [BW-1:0] data_tx2,
    input  logic [BW-1:0] data_tx3,
    input  logic          valid_tx0,
    input  logic          valid_tx1,
    input  logic          valid_tx2,
    input  logic          valid_tx3,
    output logic [BW-1:0] data_tx00,
    output logic [BW-1:0] data_tx11,
    output logic          valid_tx00,
    output logic          valid_tx11,
    output logic          phase,
    output logic          active
);

    localparam int CNT_W = $clog2(IDLE_GROUPS + 1);

`ifdef MUX_L1_IDLE_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic                 sel_q, sel_d;
    link_state_e          state_q, state_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [BW-1:0]        hold_data_q [NUM_LANES];
    logic [BW-1:0]        hold_data_d [NUM_LANES];
    logic [NUM_LANES-1:0] hold_valid_q, hold_valid_d;
    logic                 grp_run_q, grp_run_d;
    logic                 active_q, active_d;
    logic [BW-1:0]        data_tx00_q, data_tx00_d;
    logic [BW-1:0]        data_tx11_q, data_tx11_d;
    logic                 valid_tx00_q, valid_tx00_d;
    logic                 valid_tx11_q, valid_tx11_d;

    logic [BW-1:0]        in_data [NUM_LANES];
    logic [NUM_LANES-1:0] in_valid;
    logic                 slot_v_a, slot_v_b;
    logic [BW-1:0]        slot_d_a, slot_d_b;

    // Invalid slots: fill byte when enabled, else pass data in a RUN group and 0 in an IDLE group.
    function automatic logic [BW-1:0] slot_data(input logic v, input logic [BW-1:0] d,
                                                input logic run);
        logic [BW-1:0] r;
        if (v)
            r = d;
        else if (FILL_EN)
            r = IDLE_BYTE;
        else if (run)
            r = d;
        else
            r = '0;
        return r;
    endfunction

    always_comb begin
        in_data[0] = data_tx0;
        in_data[1] = data_tx1;
        in_data[2] = data_tx2;
        in_data[3] = data_tx3;
        in_valid   = {valid_tx3, valid_tx2, valid_tx1, valid_tx0};
    end

    // Capture, link FSM and idle counter; all updates happen on capture edges (sel_q == 0).
    always_comb begin
        sel_d        = ~sel_q;
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        grp_run_d    = grp_run_q;
        active_d     = (state_q == RUN);
        if (!sel_q) begin
            hold_data_d  = in_data;
            hold_valid_d = in_valid;
            if (state_q == IDLE) begin
                idle_cnt_d = '0;
                grp_run_d  = |in_valid;
                if (|in_valid)
                    state_d = RUN;
            end else begin
                // grp_run stays set so the group that triggers the exit is still emitted as RUN slots.
                grp_run_d = 1'b1;
                if (|in_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= CNT_W'(IDLE_GROUPS - 1)) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        slot_d_a     = sel_q ? hold_data_q[0] : hold_data_q[2];
        slot_d_b     = sel_q ? hold_data_q[1] : hold_data_q[3];
        slot_v_a     = grp_run_q & (sel_q ? hold_valid_q[0] : hold_valid_q[2]);
        slot_v_b     = grp_run_q & (sel_q ? hold_valid_q[1] : hold_valid_q[3]);
        valid_tx00_d = slot_v_a;
        valid_tx11_d = slot_v_b;
        data_tx00_d  = slot_data(slot_v_a, slot_d_a, grp_run_q);
        data_tx11_d  = slot_data(slot_v_b, slot_d_b, grp_run_q);
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel_q        <= 1'b0;
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            for (int i = 0; i < NUM_LANES; i++)
                hold_data_q[i] <= '0;
            hold_valid_q <= '0;
            grp_run_q    <= 1'b0;
            active_q     <= 1'b0;
            data_tx00_q  <= '0;
            data_tx11_q  <= '0;
            valid_tx00_q <= 1'b0;
            valid_tx11_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            grp_run_q    <= grp_run_d;
            active_q     <= active_d;
            data_tx00_q  <= data_tx00_d;
            data_tx11_q  <= data_tx11_d;
            valid_tx00_q <= valid_tx00_d;
            valid_tx11_q <= valid_tx11_d;
        end
    end

    assign data_tx00  = data_tx00_q;
    assign data_tx11  = data_tx11_q;
    assign valid_tx00 = valid_tx00_q;
    assign valid_tx11 = valid_tx11_q;
    assign phase      = sel_q;
    assign active     = active_q;

endmodule
